// File: rtl/soc_system_pesos_reader_pkg.sv
// Shared types and constants for the weight-RAM reader: address geometry,
// controller states, the buffered stream entry and the length clamp.
package pesos_pkg;

    localparam int PESOS_ADDR_W = 6;
    localparam int PESOS_WORDS  = 64;
    localparam int PESOS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pesos_state_t;

    // One buffered word plus the marker for the final word of a transfer.
    typedef struct packed {
        logic                    last;
        logic [PESOS_DATA_W-1:0] data;
    } pesos_entry_t;

    // Requests longer than the RAM are trimmed to one full pass over it.
    function automatic logic [PESOS_ADDR_W:0] clamp_len(input logic [PESOS_ADDR_W:0] len);
        if (len > (PESOS_ADDR_W + 1)'(PESOS_WORDS)) begin
            return (PESOS_ADDR_W + 1)'(PESOS_WORDS);
        end
        return len;
    endfunction

endpackage

// File: rtl/soc_system_pesos_reader_if.sv
// Bus bundle of the reader: Avalon-MM read port towards RAM port s2 and the
// valid/ready weight stream towards the neuron datapath.
interface soc_system_pesos_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;

    // The reader side: issues RAM reads and sources the stream.
    modport master (
        output m_address, m_chipselect, m_write, m_byteenable, m_clken,
        input  m_readdata,
        output st_data, st_valid, st_last,
        input  st_ready
    );

    // The environment side: RAM port plus stream consumer.
    modport slave (
        input  m_address, m_chipselect, m_write, m_byteenable, m_clken,
        output m_readdata,
        input  st_data, st_valid, st_last,
        output st_ready
    );
endinterface

// File: rtl/soc_system_pesos_reader_fifo.sv
// Small synchronous skid FIFO holding {last, data} entries between the RAM
// read return and the downstream stream. Flush empties it in one cycle.
module pesos_stream_fifo
    import pesos_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  pesos_entry_t             push_entry,
    input  logic                     pop,
    output pesos_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pesos_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    // An empty FIFO presents zeros so the stream data is clean when idle.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents only matter where the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/soc_system_pesos_reader.sv
// Weight reader: walks a block of the weight RAM through its s2 port and
// streams the words out. Reads are only issued when the FIFO is guaranteed
// room for the returning word, so downstream stalls never drop data.
module soc_system_pesos_reader
    import pesos_pkg::*;
#(
    parameter int ADDR_W     = PESOS_ADDR_W,
    parameter int DATA_W     = PESOS_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W:0]            length,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    soc_system_pesos_reader_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pesos_state_t      state;
    pesos_state_t      state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   ic;
    logic [ADDR_W:0]   ac;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_full;
    logic              fifo_empty;
    pesos_entry_t      head;
    pesos_entry_t      push_entry;

    assign len_clamped = clamp_len(length);
    // Credit counts the buffered words plus the one read still on its way back.
    assign credit_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
    assign issue = (state == RUN) && !abort && (ic < len_q) && !fifo_full
                   && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign pop   = !fifo_empty && bus.st_ready;
    assign flush = abort && (state != IDLE);

    assign push_entry.last = inflight_last;
    assign push_entry.data = bus.m_readdata;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    assign bus.m_chipselect = issue;
    assign bus.m_address    = issue ? (base_q + ic[ADDR_W-1:0]) : '0;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_clken      = 1'b1;
    assign bus.st_valid     = !fifo_empty;
    assign bus.st_data      = DATA_W'(head.data);
    assign bus.st_last      = head.last;

    pesos_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: issue phase, wait for the tagged last word to leave, one-cycle done.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (issue && ((ic + (ADDR_W + 1)'(1)) == len_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pop && ((ac + (ADDR_W + 1)'(1)) == len_q)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transfer parameters, issue/accept counters and the in-flight read tracker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q        <= '0;
            len_q         <= '0;
            ic            <= '0;
            ac            <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                base_q <= base_addr;
                len_q  <= len_clamped;
                ic     <= '0;
                ac     <= '0;
            end else begin
                if (issue) begin
                    ic <= ic + (ADDR_W + 1)'(1);
                end
                if (pop && (state != IDLE)) begin
                    ac <= ac + (ADDR_W + 1)'(1);
                end
            end
            inflight      <= issue;
            inflight_last <= issue && (ic == (len_q - (ADDR_W + 1)'(1)));
        end
    end

endmodule

// File: tb/tb_soc_system_pesos_reader.sv
// Bench for the weight reader: a RAM model returning 0xA0000000+address one
// cycle after each strobe, a stream monitor, a table of whole transfers and
// hand-written sequences for timing, length 0, abort and mid-transfer reset.
module tb_soc_system_pesos_reader;
    import pesos_pkg::*;

    typedef struct {
        logic [5:0]  base;
        logic [6:0]  len;
        int          mode;
        int          exp_words;
        logic [31:0] first_w;
        logic [31:0] last_w;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [5:0]  got_addr [$];
    int done_cnt = 0;
    int cs_cnt = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;
    int credit_viol = 0;
    int occ_viol = 0;
    int occ = 0;
    logic infl = 1'b0;

    int idx0, aidx0, done0, cs0, cviol0, oviol0, timed_out;

    vec_t vecs [6];
    vec_t restart_v;

    always #5 clk = ~clk;

    soc_system_pesos_reader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    soc_system_pesos_reader #(
        .ADDR_W     (6),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    // RAM port s2 model: one-cycle read latency, word i holds 0xA0000000+i.
    always @(posedge clk) begin
        if (bus.m_chipselect) begin
            bus.m_readdata <= 32'hA000_0000 + {26'd0, bus.m_address};
        end
    end

    // Stream/bus monitor plus an independent occupancy model of the buffer.
    always @(negedge clk) begin
        if (!reset_n) begin
            occ  <= 0;
            infl <= 1'b0;
        end else begin
            if (bus.st_valid && bus.st_ready) begin
                got_data.push_back(bus.st_data);
                got_last.push_back(bus.st_last);
            end
            if (bus.m_chipselect) begin
                got_addr.push_back(bus.m_address);
                cs_cnt <= cs_cnt + 1;
                if (occ + int'(infl) >= 4) credit_viol <= credit_viol + 1;
            end
            if ((occ != 0) != bus.st_valid) occ_viol <= occ_viol + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.st_valid) valid_cnt <= valid_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (abort) begin
                occ  <= 0;
                infl <= 1'b0;
            end else begin
                occ  <= occ + int'(infl) - int'(bus.st_valid && bus.st_ready);
                infl <= bus.m_chipselect;
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [5:0] b, input logic [6:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idx0   = got_data.size();
        aidx0  = got_addr.size();
        done0  = done_cnt;
        cs0    = cs_cnt;
        cviol0 = credit_viol;
        oviol0 = occ_viol;
        bus.st_ready = 1'b1;
        pulseStart(v.base, v.len);
        timed_out = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            case (v.mode)
                1:       bus.st_ready = ((cyc % 2) == 1);
                2:       bus.st_ready = !((cyc >= 20) && (cyc < 30));
                default: bus.st_ready = 1'b1;
            endcase
            if ((v.mode == 3) && (cyc == 4)) begin
                base_addr = 6'd33;
                length    = 7'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done_cnt != done0) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        bus.st_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic checkTransfer(input string tag, input vec_t v);
        int n;
        int na;
        n  = got_data.size() - idx0;
        na = got_addr.size() - aidx0;
        checkOutput({tag, " timeout"}, timed_out, 0);
        checkOutput({tag, " word count"}, n, v.exp_words);
        checkOutput({tag, " strobe count"}, cs_cnt - cs0, v.exp_words);
        checkOutput({tag, " done pulses"}, done_cnt - done0, 1);
        checkOutput({tag, " busy after"}, busy, 1'b0);
        checkOutput({tag, " credit rule"}, credit_viol - cviol0, 0);
        checkOutput({tag, " valid vs occupancy"}, occ_viol - oviol0, 0);
        if (n > 0) begin
            checkOutput({tag, " first word"}, got_data[idx0], v.first_w);
            checkOutput({tag, " final word"}, got_data[idx0 + n - 1], v.last_w);
        end
        for (int i = 0; (i < n) && (i < v.exp_words); i++) begin
            checkOutput($sformatf("%s word%0d", tag, i), got_data[idx0 + i],
                        32'hA000_0000 + 32'((int'(v.base) + i) % 64));
            checkOutput($sformatf("%s last%0d", tag, i), {31'd0, got_last[idx0 + i]},
                        {31'd0, (i == v.exp_words - 1)});
        end
        for (int i = 0; (i < na) && (i < v.exp_words); i++) begin
            checkOutput($sformatf("%s addr%0d", tag, i), {26'd0, got_addr[aidx0 + i]},
                        32'((int'(v.base) + i) % 64));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 1'b0);
        checkOutput({tag, " done"}, done, 1'b0);
        checkOutput({tag, " m_chipselect"}, bus.m_chipselect, 1'b0);
        checkOutput({tag, " m_address"}, {26'd0, bus.m_address}, 32'd0);
        checkOutput({tag, " st_valid"}, bus.st_valid, 1'b0);
        checkOutput({tag, " st_last"}, bus.st_last, 1'b0);
        checkOutput({tag, " st_data"}, bus.st_data, 32'd0);
    endtask

    initial begin
        int d_before;
        int v_before;

        vecs[0] = '{6'd0,  7'd8,   0, 8,  32'hA000_0000, 32'hA000_0007};
        vecs[1] = '{6'd62, 7'd4,   0, 4,  32'hA000_003E, 32'hA000_0001};
        vecs[2] = '{6'd0,  7'd64,  1, 64, 32'hA000_0000, 32'hA000_003F};
        vecs[3] = '{6'd10, 7'd64,  2, 64, 32'hA000_000A, 32'hA000_0009};
        vecs[4] = '{6'd7,  7'd100, 0, 64, 32'hA000_0007, 32'hA000_0006};
        vecs[5] = '{6'd20, 7'd8,   3, 8,  32'hA000_0014, 32'hA000_001B};
        restart_v = '{6'd5, 7'd2, 0, 2, 32'hA000_0005, 32'hA000_0006};

        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        base_addr    = '0;
        length       = '0;
        bus.st_ready = 1'b1;
        repeat (3) tick();
        checkResetOutputs("reset");
        checkOutput("m_write", bus.m_write, 1'b0);
        checkOutput("m_byteenable", {28'd0, bus.m_byteenable}, 32'hF);
        checkOutput("m_clken", bus.m_clken, 1'b1);
        reset_n = 1'b1;
        repeat (2) tick();

        // Exact cycle timing of a base 0, length 8 transfer with st_ready high.
        d_before = done_cnt;
        pulseStart(6'd0, 7'd8);
        @(negedge clk);
        checkOutput("t1 m_chipselect", bus.m_chipselect, 1'b1);
        checkOutput("t1 m_address", {26'd0, bus.m_address}, 32'd0);
        checkOutput("t1 busy", busy, 1'b1);
        checkOutput("t1 st_valid", bus.st_valid, 1'b0);
        @(negedge clk);
        checkOutput("t2 m_address", {26'd0, bus.m_address}, 32'd1);
        checkOutput("t2 st_valid", bus.st_valid, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checkOutput($sformatf("t%0d st_valid", j + 3), bus.st_valid, 1'b1);
            checkOutput($sformatf("t%0d st_data", j + 3), bus.st_data, 32'hA000_0000 + 32'(j));
            checkOutput($sformatf("t%0d st_last", j + 3), bus.st_last, (j == 7));
        end
        @(negedge clk);
        checkOutput("t11 done", done, 1'b1);
        checkOutput("t11 busy", busy, 1'b0);
        @(negedge clk);
        checkOutput("t12 done", done, 1'b0);
        checkOutput("timing done count", done_cnt - d_before, 1);
        tick();

        // Table of whole transfers.
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkTransfer($sformatf("vec%0d", k), vecs[k]);
        end

        // Length 0: a done pulse, no reads, no stream activity, never busy.
        d_before = done_cnt;
        cs0      = cs_cnt;
        v_before = valid_cnt;
        idx0     = busy_cnt;
        pulseStart(6'd9, 7'd0);
        repeat (6) tick();
        checkOutput("len0 done pulses", done_cnt - d_before, 1);
        checkOutput("len0 strobes", cs_cnt - cs0, 0);
        checkOutput("len0 st_valid cycles", valid_cnt - v_before, 0);
        checkOutput("len0 busy cycles", busy_cnt - idx0, 0);

        // Abort three cycles into a length-16 transfer, then restart at once.
        d_before = done_cnt;
        bus.st_ready = 1'b1;
        pulseStart(6'd0, 7'd16);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort st_valid", bus.st_valid, 1'b0);
        checkOutput("abort m_chipselect", bus.m_chipselect, 1'b0);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort no done", done_cnt - d_before, 0);
        applyStimulus(restart_v);
        checkTransfer("restart", restart_v);

        // Reset pulled low mid-transfer, then a clean transfer afterwards.
        d_before = done_cnt;
        pulseStart(6'd0, 7'd16);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        tick();
        tick();
        reset_n = 1'b1;
        checkOutput("midreset no done", done_cnt - d_before, 0);
        tick();
        applyStimulus(vecs[0]);
        checkTransfer("after reset", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
